// File: rtl/video_timing_gen.sv
// Raster timing generator: DE/HSYNC/VSYNC, pixel coordinates and start pulses for the DVI path.
// Optional colour-bar test pattern on o_r/o_g/o_b when TIMING_TPG_EN is defined.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  output logic          o_de,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [1:0]    o_ctrl,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
`ifdef TIMING_TPG_EN
  output logic          o_frame_start,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b
`else
  output logic          o_frame_start
`endif
);

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_E = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_E = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt_r;
  logic [YW-1:0] v_cnt_r;
  logic          de_s;
  logic          hs_act_s;
  logic          vs_act_s;
  logic          de_r;
  logic          hsync_r;
  logic          vsync_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          line_start_r;
  logic          frame_start_r;

  // raster position counters; a low enable parks the raster at the origin
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (!i_en) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      v_cnt_r <= (v_cnt_r == V_LAST) ? '0 : v_cnt_r + 1'b1;
    end else begin
      h_cnt_r <= h_cnt_r + 1'b1;
      v_cnt_r <= v_cnt_r;
    end
  end

  // region decode of the current counter position
  always_comb begin
    de_s     = (h_cnt_r < H_ACT_E) && (v_cnt_r < V_ACT_E);
    hs_act_s = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
    vs_act_s = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
  end

  // registered outputs; idle values while disabled
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      de_r          <= 1'b0;
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      x_r           <= '0;
      y_r           <= '0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (!i_en) begin
      de_r          <= 1'b0;
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      x_r           <= '0;
      y_r           <= '0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      de_r          <= de_s;
      hsync_r       <= hs_act_s ? HS_POL : ~HS_POL;
      vsync_r       <= vs_act_s ? VS_POL : ~VS_POL;
      x_r           <= de_s ? h_cnt_r : '0;
      y_r           <= de_s ? v_cnt_r : '0;
      line_start_r  <= de_s && (h_cnt_r == '0);
      frame_start_r <= de_s && (h_cnt_r == '0) && (v_cnt_r == '0);
    end
  end

  assign o_de          = de_r;
  assign o_hsync       = hsync_r;
  assign o_vsync       = vsync_r;
  assign o_ctrl        = {vsync_r, hsync_r};
  assign o_x           = x_r;
  assign o_y           = y_r;
  assign o_line_start  = line_start_r;
  assign o_frame_start = frame_start_r;

`ifdef TIMING_TPG_EN
  localparam logic [XW-1:0] BAR_W    = XW'(H_ACTIVE / 8);
  localparam logic [XW-1:0] BARS_END = XW'(8 * (H_ACTIVE / 8));

  logic [23:0] rgb_s;
  logic [23:0] rgb_r;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // pixels past the last full bar stay black
  always_comb begin
    rgb_s = 24'h000000;
    if (de_s && (h_cnt_r < BARS_END)) begin
      rgb_s = bar_colour(3'(h_cnt_r / BAR_W));
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // pattern register, same latency as o_de
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rgb_r <= 24'h000000;
    end else if (!i_en) begin
      rgb_r <= 24'h000000;
    end else begin
      rgb_r <= rgb_s;
    end
  end

  assign o_r = rgb_r[23:16];
  assign o_g = rgb_r[15:8];
  assign o_b = rgb_r[7:0];
`else
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen with a reduced raster, checked against a
// linear-pixel-index reference model; covers TIMING_TPG_EN outputs when defined.
module tb_video_timing_gen;

  localparam int   H_ACTIVE = 18;
  localparam int   H_FP     = 2;
  localparam int   H_SYNC   = 3;
  localparam int   H_BP     = 3;
  localparam int   V_ACTIVE = 5;
  localparam int   V_FP     = 2;
  localparam int   V_SYNC   = 2;
  localparam int   V_BP     = 1;
  localparam logic HS_POL   = 1'b1;
  localparam logic VS_POL   = 1'b0;
  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   FT       = H_TOTAL * V_TOTAL;
  localparam int   XW       = $clog2(H_TOTAL);
  localparam int   YW       = $clog2(V_TOTAL);
  localparam int   BW       = H_ACTIVE / 8;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [31:0] x;
    logic [31:0] y;
    logic        ls;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b1;
  logic          i_en = 1'b0;
  logic          o_de, o_hsync, o_vsync, o_line_start, o_frame_start;
  logic [1:0]    o_ctrl;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [7:0]    o_r, o_g, o_b;

  int   vectors = 0;
  int   miscompares = 0;
  int   p = 0;
  exp_t exp_s;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en),
    .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_ctrl(o_ctrl),
    .o_x(o_x), .o_y(o_y), .o_line_start(o_line_start),
`ifdef TIMING_TPG_EN
    .o_frame_start(o_frame_start), .o_r(o_r), .o_g(o_g), .o_b(o_b)
`else
    .o_frame_start(o_frame_start)
`endif
  );

`ifndef TIMING_TPG_EN
  assign o_r = 8'h00;
  assign o_g = 8'h00;
  assign o_b = 8'h00;
`endif

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // outputs expected one clock after the raster sits at linear pixel index pix
  function automatic exp_t ref_out(input int pix, input bit en);
    exp_t e;
    int h, v;
    e    = '0;
    e.hs = ~HS_POL;
    e.vs = ~VS_POL;
    h    = pix % H_TOTAL;
    v    = pix / H_TOTAL;
    if (en) begin
      e.de  = (h < H_ACTIVE) && (v < V_ACTIVE);
      e.hs  = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      e.vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      e.x   = e.de ? h : 0;
      e.y   = e.de ? v : 0;
      e.ls  = e.de && (h == 0);
      e.fs  = e.ls && (v == 0);
      e.rgb = (e.de && h < 8 * BW) ? BARS[h / BW] : 24'h000000;
    end
    return e;
  endfunction

  task automatic compare_all();
    check_val("de", 32'(o_de), 32'(exp_s.de));
    check_val("hsync", 32'(o_hsync), 32'(exp_s.hs));
    check_val("vsync", 32'(o_vsync), 32'(exp_s.vs));
    check_val("ctrl", 32'(o_ctrl), 32'({exp_s.vs, exp_s.hs}));
    check_val("x", 32'(o_x), exp_s.x);
    check_val("y", 32'(o_y), exp_s.y);
    check_val("line_start", 32'(o_line_start), 32'(exp_s.ls));
    check_val("frame_start", 32'(o_frame_start), 32'(exp_s.fs));
`ifdef TIMING_TPG_EN
    check_val("rgb", 32'({o_r, o_g, o_b}), 32'(exp_s.rgb));
`endif
  endtask

  task automatic step(input bit en);
    @(negedge i_clk);
    i_en  = en;
    exp_s = ref_out(p, en);
    p     = en ? (p + 1) % FT : 0;
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  initial begin
    int de_cnt, ls_cnt, fs_cnt, hs_cnt, vs_cnt, fall_t, hs_t, vs_t, target;
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    fall_t = -1; hs_t = -1; vs_t = -1;

    // async reset with no clock edge
    #2 i_rstn = 1'b0;
    #1;
    p     = 0;
    exp_s = ref_out(0, 1'b0);
    compare_all();
    repeat (3) @(posedge i_clk);
    #3 i_rstn = 1'b1;
    step(1'b1);
    check_val("fs_after_rst", 32'(o_frame_start), 32'd1);

    // one full undisturbed frame, tallied from the DUT outputs
    for (int t = 0; t < FT; t++) begin
      if (t > 0) step(1'b1);
      if (o_de) de_cnt++;
      if (o_line_start) ls_cnt++;
      if (o_frame_start) fs_cnt++;
      if (!o_de && fall_t < 0) fall_t = t;
      if (o_hsync == HS_POL) begin
        hs_cnt++;
        if (hs_t < 0) hs_t = t;
      end
      if (o_vsync == VS_POL) begin
        vs_cnt++;
        if (vs_t < 0) vs_t = t;
      end
    end
    step(1'b1);
    check_val("fs_period", 32'(o_frame_start), 32'd1);
    check_val("de_total", de_cnt, H_ACTIVE * V_ACTIVE);
    check_val("de_run", fall_t, H_ACTIVE);
    check_val("active_lines", ls_cnt, V_ACTIVE);
    check_val("fs_per_frame", fs_cnt, 1);
    check_val("hs_clocks", hs_cnt, H_SYNC * V_TOTAL);
    check_val("hs_offset", hs_t - fall_t, H_FP);
    check_val("vs_clocks", vs_cnt, V_SYNC * H_TOTAL);
    check_val("vs_start", vs_t, (V_ACTIVE + V_FP) * H_TOTAL);

    // disable mid-frame at (x=5,y=2), then restart
    target = 2 * H_TOTAL + 5;
    for (int i = 0; i < FT && p != target; i++) step(1'b1);
    step(1'b1);
    check_val("pre_off_x", 32'(o_x), 32'd5);
    step(1'b0);
    check_val("en_off_de", 32'(o_de), 32'd0);
    check_val("en_off_y", 32'(o_y), 32'd0);
    step(1'b0);
    step(1'b1);
    check_val("fs_after_en", 32'(o_frame_start), 32'd1);

    // async reset during the hsync pulse
    for (int i = 0; i < 2 * H_TOTAL; i++) begin
      step(1'b1);
      if (o_hsync == HS_POL) break;
    end
    check_val("in_hsync", 32'(o_hsync), 32'(HS_POL));
    #2 i_rstn = 1'b0;
    #1;
    p     = 0;
    exp_s = ref_out(0, 1'b0);
    compare_all();
    @(posedge i_clk);
    #3 i_rstn = 1'b1;
    step(1'b1);
    check_val("fs_after_rst2", 32'(o_frame_start), 32'd1);

    // randomized enable traffic
    repeat (3 * FT) step($urandom_range(0, 15) != 0);
    repeat (FT + 4) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
